// File: rtl/cache_traffic_gen.sv
// Programmable address-stream generator and response checker for the GT_cache bench.
// Issues one request at a time and tallies hit/miss/data responses into counters and sticky flags.
module cache_traffic_gen #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 8,
    parameter int          OFFSET_W  = 2,
    parameter int          CNT_W     = 16,
    parameter int          HOT_LINES = 4,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  num_req,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic              hit,
    input  logic              miss,
    input  logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  req_count,
    output logic [DATA_W-1:0] checksum,
    output logic              err_proto,
    output logic              err_timeout
);

    localparam int IDX_W = (HOT_LINES > 1) ? $clog2(HOT_LINES) : 1;
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(1) << OFFSET_W;
    localparam logic [ADDR_W-1:0] OFF_MASK = STEP - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TAPS     = ADDR_W'(LFSR_TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_SEQ    = 2'd0,
        M_STRIDE = 2'd1,
        M_RANDOM = 2'd2,
        M_HOT    = 2'd3
    } mode_t;

    state_t            state, state_next;
    mode_t             mode_q;
    logic [ADDR_W-1:0] base_q, stride_q, cur_addr, lfsr;
    logic [CNT_W-1:0]  num_q;
    logic [IDX_W-1:0]  idx;
    logic [TO_W-1:0]   tcnt;

    logic              do_load, do_accept, do_resp, do_timeout;
    logic [ADDR_W-1:0] lfsr_step, addr_next;
    logic [IDX_W-1:0]  idx_next;

    // Assertion reaches the FSM asynchronously; release waits two clean edges.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) state <= S_IDLE;
        else            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_accept  = 1'b0;
        do_resp    = 1'b0;
        do_timeout = 1'b0;
        req_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    do_load    = 1'b1;
                    state_next = (num_req == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_valid = 1'b1;
                busy      = 1'b1;
                if (req_ready) begin
                    do_accept  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (resp_valid) begin
                    do_resp    = 1'b1;
                    state_next = (req_count == num_q) ? S_DONE : S_ISSUE;
                end else if (tcnt == TO_W'(TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
        if (int'(idx) == HOT_LINES - 1) idx_next = '0;
        else                            idx_next = idx + 1'b1;
        unique case (mode_q)
            M_SEQ:    addr_next = cur_addr + STEP;
            M_STRIDE: addr_next = cur_addr + stride_q;
            M_RANDOM: addr_next = lfsr_step & ~OFF_MASK;
            default:  addr_next = base_q + (ADDR_W'(idx_next) << OFFSET_W);
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            mode_q      <= M_SEQ;
            base_q      <= '0;
            stride_q    <= '0;
            num_q       <= '0;
            cur_addr    <= '0;
            lfsr        <= '0;
            idx         <= '0;
            tcnt        <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            req_count   <= '0;
            checksum    <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else if (do_load) begin
            mode_q      <= mode_t'(mode);
            base_q      <= base_addr;
            stride_q    <= stride;
            num_q       <= num_req;
            cur_addr    <= base_addr;
            lfsr        <= (base_addr == '0) ? ADDR_W'(1) : base_addr;
            idx         <= '0;
            tcnt        <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            req_count   <= '0;
            checksum    <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (do_accept) begin
                req_count <= sat_inc(req_count);
                cur_addr  <= addr_next;
                tcnt      <= '0;
                if (mode_q == M_RANDOM) lfsr <= lfsr_step;
                if (mode_q == M_HOT)    idx  <= idx_next;
            end else if (state == S_WAIT && !resp_valid) begin
                tcnt <= tcnt + 1'b1;
            end
            if (do_resp) begin
                checksum <= checksum ^ resp_data;
                if (hit && !miss) hit_count  <= sat_inc(hit_count);
                if (miss && !hit) miss_count <= sat_inc(miss_count);
            end
            // Stray strobes and ambiguous classifications are both protocol violations.
            if (resp_valid && (state != S_WAIT || hit == miss)) err_proto <= 1'b1;
            if (do_timeout) err_timeout <= 1'b1;
        end
    end

    assign req_addr = cur_addr;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench for cache_traffic_gen: table-driven address-stream runs plus
// hand-written sequences for checksum/protocol errors, stalls, timeout and reset.
module tb_cache_traffic_gen;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr, stride;
    logic [15:0] num_req;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid, hit, miss;
    logic [7:0]  resp_data;
    logic        busy, done;
    logic [15:0] hit_count, miss_count, req_count;
    logic [7:0]  checksum;
    logic        err_proto, err_timeout;

    int total = 0;
    int bad   = 0;

    cache_traffic_gen dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .mode(mode),
        .base_addr(base_addr), .stride(stride), .num_req(num_req),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .hit(hit), .miss(miss), .resp_data(resp_data),
        .busy(busy), .done(done), .hit_count(hit_count), .miss_count(miss_count),
        .req_count(req_count), .checksum(checksum),
        .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]       mode;
        logic [31:0]      base;
        logic [31:0]      stride;
        logic [15:0]      num;
        logic [0:5][31:0] addr;
        logic [5:0]       mask;   // bit i: response i is a hit (1) or a miss (0)
        logic [7:0]       seed;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_valid"},   req_valid,   0);
        check({tag, " req_addr"},    req_addr,    0);
        check({tag, " busy"},        busy,        0);
        check({tag, " done"},        done,        0);
        check({tag, " hit_count"},   hit_count,   0);
        check({tag, " miss_count"},  miss_count,  0);
        check({tag, " req_count"},   req_count,   0);
        check({tag, " checksum"},    checksum,    0);
        check({tag, " err_proto"},   err_proto,   0);
        check({tag, " err_timeout"}, err_timeout, 0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [7:0] exp_cs;
        int exp_hit, exp_miss;
        exp_cs = 8'h00; exp_hit = 0; exp_miss = 0;
        mode = v.mode; base_addr = v.base; stride = v.stride; num_req = v.num;
        req_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(v.num); i++) begin
            check($sformatf("v%0d valid%0d", id, i), req_valid, 1);
            check($sformatf("v%0d addr%0d", id, i), req_addr, v.addr[i]);
            tick();
            resp_valid = 1'b1;
            hit        = v.mask[i];
            miss       = !v.mask[i];
            resp_data  = v.seed + 8'(i * 37);
            exp_cs     = exp_cs ^ resp_data;
            if (v.mask[i]) exp_hit++; else exp_miss++;
            check($sformatf("v%0d busy%0d", id, i), busy, 1);
            tick();
            resp_valid = 1'b0; hit = 1'b0; miss = 1'b0;
        end
        check($sformatf("v%0d done", id), done, 1);
        check($sformatf("v%0d busy_end", id), busy, 0);
        check($sformatf("v%0d req_count", id), req_count, v.num);
        check($sformatf("v%0d hit_count", id), hit_count, exp_hit);
        check($sformatf("v%0d miss_count", id), miss_count, exp_miss);
        check($sformatf("v%0d checksum", id), checksum, exp_cs);
        check($sformatf("v%0d err_proto", id), err_proto, 0);
        check($sformatf("v%0d err_timeout", id), err_timeout, 0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'h0000_0100, 32'h0, 16'd4,
                    {32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0}, 6'b001111, 8'h3C};
        vecs[1] = '{2'd1, 32'hFFFF_FFF8, 32'h8, 16'd3,
                    {32'hFFFF_FFF8, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0}, 6'b000010, 8'h81};
        vecs[2] = '{2'd3, 32'h0000_0040, 32'h0, 16'd6,
                    {32'h40, 32'h44, 32'h48, 32'h4C, 32'h40, 32'h44}, 6'b101010, 8'h07};
        vecs[3] = '{2'd2, 32'h0000_0000, 32'h0, 16'd4,
                    {32'h0, 32'h8020_0000, 32'hC030_0000, 32'h6018_0000, 32'h0, 32'h0},
                    6'b000110, 8'hE1};
        vecs[4] = vecs[3];
        vecs[5] = '{2'd1, 32'h0000_1000, 32'h10, 16'd2,
                    {32'h1000, 32'h1010, 32'h0, 32'h0, 32'h0, 32'h0}, 6'b000001, 8'h55};

        RST_N = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; stride = '0; num_req = '0;
        req_ready = 1'b0; resp_valid = 1'b0; hit = 1'b0; miss = 1'b0; resp_data = '0;
        repeat (3) tick();
        check_all_zero("reset");
        RST_N = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Checksum and ambiguous hit+miss response.
        mode = 2'd0; base_addr = 32'h0; num_req = 16'd2; req_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        resp_valid = 1'b1; hit = 1'b1; miss = 1'b0; resp_data = 8'h5A;
        tick();
        resp_valid = 1'b0;
        check("cs hit_after_first", hit_count, 1);
        tick();
        resp_valid = 1'b1; hit = 1'b1; miss = 1'b1; resp_data = 8'hA5;
        tick();
        resp_valid = 1'b0; hit = 1'b0; miss = 1'b0;
        check("cs done", done, 1);
        check("cs checksum", checksum, 8'hFF);
        check("cs hit_count", hit_count, 1);
        check("cs miss_count", miss_count, 0);
        check("cs err_proto", err_proto, 1);

        // num_req = 0 finishes immediately and clears stale errors.
        num_req = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("zero done", done, 1);
        check("zero busy", busy, 0);
        check("zero req_valid", req_valid, 0);
        check("zero req_count", req_count, 0);
        check("zero err_proto", err_proto, 0);

        // Stalled request, start-while-busy, then timeout.
        mode = 2'd0; base_addr = 32'h200; num_req = 16'd2; req_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall valid%0d", i), req_valid, 1);
            check($sformatf("stall addr%0d", i), req_addr, 32'h200);
            if (i == 4) begin
                start = 1'b1; base_addr = 32'h9000;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("stall req_count", req_count, 0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("to req_valid_low", req_valid, 0);
        check("to req_count", req_count, 1);
        repeat (255) tick();
        check("to done_early", done, 0);
        check("to err_early", err_timeout, 0);
        tick();
        check("to done", done, 1);
        check("to err_timeout", err_timeout, 1);
        check("to err_proto_pre", err_proto, 0);
        resp_valid = 1'b1; hit = 1'b1;
        tick();
        resp_valid = 1'b0; hit = 1'b0;
        check("stray err_proto", err_proto, 1);
        check("stray hit_count", hit_count, 0);

        // Asynchronous reset mid-WAIT, then synchronised release.
        mode = 2'd0; base_addr = 32'h300; num_req = 16'd3; req_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        resp_valid = 1'b1; hit = 1'b1;
        tick();
        resp_valid = 1'b0; hit = 1'b0;
        tick();
        check("rst pre_busy", busy, 1);
        check("rst pre_hits", hit_count, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        #2;
        RST_N = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check("sync held_2", busy, 0);
        tick();
        start = 1'b0;
        check("sync release", busy, 1);
        check("sync addr", req_addr, 32'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
